// File: rtl/tlu_event_framer_if.sv
// Stream bundle between the TLU master FIFO, the event framer and the
// 32-bit readout FIFO. The framer takes the master side: it pops the
// 16-bit source and drives the 32-bit output stream.
interface tlu_event_framer_if;
  // 16-bit first-word-fall-through source (TLU master FIFO)
  logic        SRC_EMPTY;
  logic [15:0] SRC_DATA;
  logic        SRC_READ;

  // 32-bit valid/ready output stream (readout FIFO)
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport master (
    input  SRC_EMPTY,
    input  SRC_DATA,
    output SRC_READ,
    output OUT_DATA,
    output OUT_VALID,
    input  OUT_READY
  );

  modport slave (
    output SRC_EMPTY,
    output SRC_DATA,
    input  SRC_READ,
    input  OUT_DATA,
    input  OUT_VALID,
    output OUT_READY
  );
endinterface

// File: rtl/tlu_event_framer.sv
// TLU event framer: drains WORDS_PER_EVT 16-bit words per event from the TLU
// master FIFO and emits one header word plus WORDS_PER_EVT/2 packed 32-bit
// data words on a registered valid/ready stream. The header carries a
// free-running 16-bit event sequence number so software can spot drops.
module tlu_event_framer #(
  parameter logic [3:0] HEADER_ID     = 4'hC,
  parameter int         WORDS_PER_EVT = 8    // must be even and >= 2
) (
  input  logic                   BUS_CLK,
  input  logic                   RST,
  input  logic                   EN,
  tlu_event_framer_if.master     bus,
  output logic [15:0]            EVENT_CNT,
  output logic                   BUSY
);

  localparam int PAIRS  = WORDS_PER_EVT / 2;
  localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_LO,
    RD_HI,
    SEND
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [PAIR_W-1:0]   pair_cnt;
  logic [15:0]         lo_word;
  logic [15:0]         event_cnt;
  logic [31:0]         out_data;
  logic                out_valid;

  // Control strobes decoded from the current state and handshakes
  logic                pop;
  logic                load_hdr;
  logic                latch_lo;
  logic                load_data;
  logic                accept;
  logic                pair_done;
  logic                evt_done;

  // State register.
  // NOTE: reset here is synchronous (sampled on BUS_CLK) because RST is shared
  // with the upstream FIFO, which also resets on the clock edge.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      // NOTE: all clocked state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process ordering.
      state <= state_next;
    end
  end

  // Next-state and control strobe decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_next = state;
    pop        = 1'b0;
    load_hdr   = 1'b0;
    latch_lo   = 1'b0;
    load_data  = 1'b0;
    accept     = 1'b0;
    pair_done  = 1'b0;
    evt_done   = 1'b0;

    case (state)
      IDLE: begin
        // EN only gates the start of an event; an event in flight always completes.
        if (EN && !bus.SRC_EMPTY) begin
          load_hdr   = 1'b1;
          state_next = HDR;
        end
      end

      HDR: begin
        // OUT_VALID is always set in HDR, so OUT_READY alone is the accept.
        if (bus.OUT_READY) begin
          accept     = 1'b1;
          state_next = RD_LO;
        end
      end

      RD_LO: begin
        if (!bus.SRC_EMPTY) begin
          pop        = 1'b1;
          latch_lo   = 1'b1;
          state_next = RD_HI;
        end
      end

      RD_HI: begin
        if (!bus.SRC_EMPTY) begin
          pop        = 1'b1;
          load_data  = 1'b1;
          state_next = SEND;
        end
      end

      SEND: begin
        if (bus.OUT_READY) begin
          accept    = 1'b1;
          pair_done = 1'b1;
          if (pair_cnt == LAST_PAIR) begin
            evt_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RD_LO;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output word register, low-word holding register and counters.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      lo_word   <= '0;
      pair_cnt  <= '0;
      event_cnt <= '0;
    end else begin
      if (load_hdr) begin
        // Header carries the sequence number of this event (pre-increment).
        out_data  <= {HEADER_ID, 12'h000, event_cnt};
        out_valid <= 1'b1;
      end

      if (latch_lo) begin
        lo_word <= bus.SRC_DATA;
      end

      if (load_data) begin
        // Low 16-bit word arrives first and lands in the low half.
        out_data  <= {bus.SRC_DATA, lo_word};
        out_valid <= 1'b1;
      end

      if (accept) begin
        out_valid <= 1'b0;
      end

      if (pair_done) begin
        if (evt_done) begin
          pair_cnt  <= '0;
          event_cnt <= event_cnt + 16'd1;  // wraps FFFF -> 0000
        end else begin
          pair_cnt  <= pair_cnt + 1'b1;
        end
      end
    end
  end

  // The pop is combinational against the FWFT source; reset masks it so the
  // shared-reset FIFO never sees a read while both sides are realigning.
  assign bus.SRC_READ  = pop && !RST;
  assign bus.OUT_DATA  = out_data;
  assign bus.OUT_VALID = out_valid;
  assign EVENT_CNT     = event_cnt;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_tlu_event_framer.sv
// Self-checking bench for tlu_event_framer: a table of single-event vectors
// plus hand-written sequences for EN gating, back-to-back events, counter
// wrap and mid-event reset. A queue models the FWFT source FIFO.
module tb_tlu_event_framer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] event_cnt;
  logic        busy;

  tlu_event_framer_if bus();

  tlu_event_framer #(
    .HEADER_ID    (4'hC),
    .WORDS_PER_EVT(8)
  ) dut (
    .BUS_CLK  (clk),
    .RST      (rst),
    .EN       (en),
    .bus      (bus),
    .EVENT_CNT(event_cnt),
    .BUSY     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][15:0] words;    // words[0] is the first word popped
    int               stall;    // OUT_READY=0 cycles on the 2nd data word
    logic [31:0]      exp_hdr;
    logic [3:0][31:0] exp_d;    // exp_d[0] is the first data word
    logic [15:0]      exp_cnt;  // EVENT_CNT after the event
  } vec_t;

  vec_t vecs[4];

  int total = 0;
  int bad   = 0;

  logic [15:0] src_q[$];
  logic [31:0] acc_q[$];
  int          acc_cyc_q[$];
  int          cyc            = 0;
  int          pops           = 0;
  int          rd_empty_viol  = 0;
  int          stall_pop_viol = 0;
  int          hold_viol      = 0;
  logic        prev_stall     = 1'b0;
  logic        prev_rst       = 1'b0;
  logic [31:0] prev_data      = '0;
  logic        last_rd        = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: called at a negedge with inputs already set. Samples the
  // DUT just before the rising edge, then models the source FIFO pop.
  task automatic cycle();
    logic        rd;
    logic        vld;
    logic        rdy;
    logic [31:0] dat;
    bus.SRC_EMPTY = (src_q.size() == 0);
    bus.SRC_DATA  = (src_q.size() == 0) ? 16'h0000 : src_q[0];
    #4;
    rd  = bus.SRC_READ;
    vld = bus.OUT_VALID;
    rdy = bus.OUT_READY;
    dat = bus.OUT_DATA;
    if (rd && bus.SRC_EMPTY) rd_empty_viol++;
    if (rd && vld && !rdy) stall_pop_viol++;
    if (prev_stall && !prev_rst && (!vld || dat !== prev_data)) hold_viol++;
    prev_stall = vld && !rdy;
    prev_data  = dat;
    prev_rst   = rst;
    if (vld && rdy && !rst) begin
      acc_q.push_back(dat);
      acc_cyc_q.push_back(cyc);
    end
    last_rd = rd;
    @(posedge clk);
    if (rd) begin
      pops++;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    src_q.delete();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " out_valid"}, 32'(bus.OUT_VALID), 32'd0);
    check({tag, " out_data"},  bus.OUT_DATA,       32'h0);
    check({tag, " event_cnt"}, 32'(event_cnt),     32'h0);
    check({tag, " busy"},      32'(busy),          32'd0);
  endtask

  task automatic push_words(input logic [7:0][15:0] w);
    for (int i = 0; i < 8; i++) src_q.push_back(w[i]);
  endtask

  // Runs one complete event from IDLE and checks frame, counts and timing.
  task automatic run_event(input string tag, input logic [7:0][15:0] words,
                           input int stall, input int drop_en_after,
                           input logic [31:0] exp_hdr, input logic [3:0][31:0] exp_d,
                           input logic [15:0] exp_cnt);
    int base_pops;
    int start_cyc;
    int stall_left;
    int guard;
    acc_q.delete();
    acc_cyc_q.delete();
    push_words(words);
    base_pops  = pops;
    start_cyc  = cyc;
    stall_left = stall;
    guard      = 0;
    en         = 1'b1;
    while (acc_q.size() < 5 && guard < 100) begin
      bus.OUT_READY = 1'b1;
      if (acc_q.size() == 2 && bus.OUT_VALID && stall_left > 0) begin
        bus.OUT_READY = 1'b0;
        stall_left--;
      end
      if (drop_en_after >= 0 && acc_q.size() >= drop_en_after) en = 1'b0;
      cycle();
      guard++;
    end
    bus.OUT_READY = 1'b1;
    check({tag, " frame_len"}, 32'(acc_q.size()), 32'd5);
    if (acc_q.size() == 5) begin
      check({tag, " header"}, acc_q[0], exp_hdr);
      for (int k = 0; k < 4; k++)
        check($sformatf("%s data%0d", tag, k), acc_q[k+1], exp_d[k]);
      check({tag, " hdr_latency"},   32'(acc_cyc_q[0] - start_cyc), 32'd1);
      check({tag, " event_latency"}, 32'(acc_cyc_q[4] - start_cyc), 32'(13 + stall));
    end
    check({tag, " pops"},      32'(pops - base_pops), 32'd8);
    check({tag, " event_cnt"}, 32'(event_cnt),        32'(exp_cnt));
    check({tag, " busy_end"},  32'(busy),             32'd0);
  endtask

  logic [7:0][15:0] w_seq;
  logic [3:0][31:0] d_seq;
  logic [7:0][15:0] w_b;
  logic [3:0][31:0] d_b;

  initial begin
    int base_pops;
    int guard;
    int saw_valid;
    int saw_busy;

    w_seq = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
    d_seq = {32'h00080007, 32'h00060005, 32'h00040003, 32'h00020001};
    w_b   = {16'h0010, 16'h000F, 16'h000E, 16'h000D, 16'h000C, 16'h000B, 16'h000A, 16'h0009};
    d_b   = {32'h0010000F, 32'h000E000D, 32'h000C000B, 32'h000A0009};

    vecs[0] = '{words: w_seq, stall: 0, exp_hdr: 32'hC0000000, exp_d: d_seq, exp_cnt: 16'h0001};
    vecs[1] = '{words: w_seq, stall: 5, exp_hdr: 32'hC0000001, exp_d: d_seq, exp_cnt: 16'h0002};
    vecs[2] = '{words: {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111},
                stall: 0, exp_hdr: 32'hC0000002,
                exp_d: {32'h88887777, 32'h66665555, 32'h44443333, 32'h22221111},
                exp_cnt: 16'h0003};
    vecs[3] = '{words: {16'hFFFF, 16'h0000, 16'hBEEF, 16'hDEAD, 16'h5A5A, 16'hA5A5, 16'h0000, 16'hFFFF},
                stall: 2, exp_hdr: 32'hC0000003,
                exp_d: {32'hFFFF0000, 32'hBEEFDEAD, 32'h5A5AA5A5, 32'h0000FFFF},
                exp_cnt: 16'h0004};

    rst           = 1'b1;
    en            = 1'b0;
    bus.SRC_EMPTY = 1'b1;
    bus.SRC_DATA  = 16'h0000;
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    apply_reset();
    check_reset("reset0");

    // Table-driven single events (plain, backpressured, patterns)
    for (int v = 0; v < 4; v++)
      run_event($sformatf("vec%0d", v), vecs[v].words, vecs[v].stall, -1,
                vecs[v].exp_hdr, vecs[v].exp_d, vecs[v].exp_cnt);

    // EN low with data waiting: nothing starts
    en = 1'b0;
    push_words(w_seq);
    base_pops = pops;
    saw_valid = 0;
    saw_busy  = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.OUT_VALID) saw_valid++;
      if (busy) saw_busy++;
    end
    check("en_off pops",  32'(pops - base_pops), 32'd0);
    check("en_off valid", 32'(saw_valid),        32'd0);
    check("en_off busy",  32'(saw_busy),         32'd0);
    src_q.delete();

    // EN dropped during the third data word: event still completes
    run_event("en_drop", w_seq, 0, 3, 32'hC0000004, d_seq, 16'h0005);

    // Reset mid-event in RD_HI of the third pair
    apply_reset();
    check_reset("reset1");
    push_words(w_seq);
    base_pops = pops;
    en        = 1'b1;
    guard     = 0;
    while ((pops - base_pops) < 5 && guard < 60) begin
      cycle();
      guard++;
    end
    check("rst_mid reach_rd_hi", 32'(pops - base_pops), 32'd5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    src_q.delete();
    check("rst_mid src_read_in_rst", 32'(last_rd),         32'd0);
    check("rst_mid out_valid",       32'(bus.OUT_VALID),   32'd0);
    check("rst_mid busy",            32'(busy),            32'd0);
    check("rst_mid event_cnt",       32'(event_cnt),       32'd0);
    run_event("after_rst", w_seq, 0, -1, 32'hC0000000, d_seq, 16'h0001);

    // Reset while a header is stalled: OUT_VALID drops on that edge
    push_words(w_seq);
    base_pops     = pops;
    en            = 1'b1;
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("hdr_stall valid", 32'(bus.OUT_VALID),   32'd1);
    check("hdr_stall data",  bus.OUT_DATA,         32'hC0000001);
    check("hdr_stall pops",  32'(pops - base_pops), 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    src_q.delete();
    bus.OUT_READY = 1'b1;
    check("hdr_stall_rst valid", 32'(bus.OUT_VALID), 32'd0);
    check("hdr_stall_rst busy",  32'(busy),          32'd0);

    // Two queued events back-to-back from reset
    apply_reset();
    check_reset("reset2");
    acc_q.delete();
    acc_cyc_q.delete();
    push_words(w_seq);
    push_words(w_b);
    en    = 1'b1;
    guard = 0;
    while (acc_q.size() < 10 && guard < 200) begin
      cycle();
      guard++;
    end
    check("b2b frame_len", 32'(acc_q.size()), 32'd10);
    if (acc_q.size() == 10) begin
      check("b2b hdr0", acc_q[0], 32'hC0000000);
      check("b2b hdr1", acc_q[5], 32'hC0000001);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("b2b ev0 data%0d", k), acc_q[k+1], d_seq[k]);
        check($sformatf("b2b ev1 data%0d", k), acc_q[k+6], d_b[k]);
      end
      check("b2b idle_gap", 32'(acc_cyc_q[5] - acc_cyc_q[4]), 32'd2);
    end
    cycle();
    check("b2b event_cnt", 32'(event_cnt), 32'd2);

    // Counter wrap: preload FFFF while idle
    force dut.event_cnt = 16'hFFFF;
    cycle();
    release dut.event_cnt;
    cycle();
    check("wrap preload", 32'(event_cnt), 32'h0000FFFF);
    run_event("wrap_ffff", w_seq, 0, -1, 32'hC000FFFF, d_seq, 16'h0000);
    run_event("wrap_0000", w_b,   0, -1, 32'hC0000000, d_b,   16'h0001);

    // Protocol invariants over the whole run
    check("read_while_empty",  32'(rd_empty_viol),  32'd0);
    check("pop_during_stall",  32'(stall_pop_viol), 32'd0);
    check("data_hold_stall",   32'(hold_viol),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
